// File: rtl/counter_binary_down_reload.sv
// counter_binary_down_reload
// Loadable binary down-counter / interval timer. A programmed value is counted
// down to zero on enabled edges; the edge after zero pulses `borrow` for one
// cycle. A small IDLE/RUN/DONE FSM gates counting.
//
// Optional feature macro: COUNTER_DOWN_AUTO_RELOAD_EN
//   undefined (default): one-shot; underflow parks the counter at 0 in DONE.
//   defined            : periodic; underflow reloads from reload_reg and stays
//                        in RUN, so DONE is never entered.
module counter_binary_down_reload #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  input  logic             start,
  output logic [NBITS-1:0] counter,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [NBITS-1:0] reload_reg, reload_next;
  logic [NBITS-1:0] counter_next;
  logic             borrow_next;

  // Register all state; reset clears everything immediately, even mid-count.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      reload_reg <= '0;
      borrow     <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      reload_reg <= reload_next;
      borrow     <= borrow_next;
    end
  end

  // Next-state and datapath decode; priority is load > start > count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next   = state;
    counter_next = counter;
    reload_next  = reload_reg;
    borrow_next  = 1'b0;

    if (load) begin
      // Load wins in any state and silently swallows a simultaneous start.
      reload_next  = load_value;
      counter_next = load_value;
      state_next   = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // Counter keeps the loaded value; the first enabled RUN edge counts.
          if (start) state_next = RUN;
        end

        RUN: begin
          // start is ignored here: no restart while running.
          if (enable) begin
            if (counter != '0) begin
              counter_next = counter - NBITS'(1);
            end else begin
              // Zero is handled explicitly, so the subtraction never wraps.
              borrow_next = 1'b1;
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
              counter_next = reload_reg;
`else
              counter_next = '0;
              state_next   = DONE;
`endif
            end
          end
        end

        DONE: begin
          if (start) begin
            counter_next = reload_reg;
            state_next   = RUN;
          end
        end

        default: begin
          state_next   = IDLE;
          counter_next = '0;
        end
      endcase
    end
  end

  // Status flags decoded purely from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule
